// File: rtl/instruction_loader.sv
// instruction_loader: receives a byte stream and writes it as big-endian 32-bit words into instruction memory.
// Ports: clk/reset (sync, active-low); start+word_count request a load of 1..DEPTH_WORDS words;
// abort cancels a load; in_valid/in_data/in_ready form the byte stream; WrEn/WrAddress/WrData
// drive the memory write port; cpu_hold stalls the CPU during a load; done/err are one-cycle pulses.
module instruction_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  word_count,
  input  logic        abort,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        WrEn,
  output logic [31:0] WrAddress,
  output logic [31:0] WrData,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);
  localparam logic [9:0] DMAX = 10'(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
  state_t st, nxt;
  logic [1:0] bcnt;
  logic [8:0] idx, cnt;
  logic [31:0] word;
  logic err_q, ok, take, last;
  assign ok = start && word_count != 9'd0 && {1'b0, word_count} <= DMAX;
  assign take = st == RECV && in_valid;
  assign last = idx + 9'd1 == cnt;
  always_comb begin
    nxt = st;
    case (st)
      IDLE:  nxt = ok ? RECV : IDLE;
      RECV:  nxt = abort ? IDLE : (take && bcnt == 2'd3) ? WRITE : RECV;
      WRITE: nxt = abort ? IDLE : last ? DONE : RECV;
      default: nxt = IDLE;
    endcase
  end
  // bcnt wraps to 0 on the 4th byte, so the next word starts clean without an explicit clear;
  // shifting left places byte 0 in [31:24] once all four have arrived.
  always_ff @(posedge clk) begin
    if (!reset) begin
      st <= IDLE;
      bcnt <= 2'd0;
      idx <= 9'd0;
      cnt <= 9'd0;
      word <= 32'd0;
      err_q <= 1'b0;
    end else begin
      st <= nxt;
      err_q <= st == IDLE && start && !ok;
      if (st == IDLE && ok) begin
        cnt <= word_count;
        bcnt <= 2'd0;
        idx <= 9'd0;
      end
      if (take) begin
        word <= {word[23:0], in_data};
        bcnt <= bcnt + 2'd1;
      end
      if (st == WRITE && !abort) idx <= idx + 9'd1;
    end
  end
  assign in_ready = st == RECV;
  assign WrEn = st == WRITE && !abort;
  assign WrAddress = st == WRITE ? BASE_ADDR + {21'd0, idx, 2'b00} : 32'd0;
  assign WrData = st == WRITE ? word : 32'd0;
  assign cpu_hold = st != IDLE;
  assign done = st == DONE;
  assign err = err_q;
endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: directed and randomized loads checked against a byte-list reference model.
module tb_instruction_loader;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0, in_valid = 1'b0;
  logic [8:0] word_count = 9'd0;
  logic [7:0] in_data = 8'd0;
  logic in_ready, WrEn, cpu_hold, done, err;
  logic [31:0] WrAddress, WrData;
  int tests = 0, fails = 0;
  logic [7:0] bq[$];
  logic [31:0] ga[$], gd[$];
  always #5 clk = ~clk;
  instruction_loader dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .WrEn(WrEn),
    .WrAddress(WrAddress), .WrData(WrData), .cpu_hold(cpu_hold), .done(done), .err(err)
  );
  task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic load(input int n, input int mode, input int ab, input int rs);
    int nb, cyc, nd, ne, dcyc, exp_w, budget;
    bit fin, to, rst_chk, prev_rdy, prev_wr, ab_pend, rs_pend, okn, normal;
    if (bq.size() == 0) for (int i = 0; i < 4 * n; i++) bq.push_back(8'($urandom));
    for (int i = 0; i < 8; i++) bq.push_back(8'($urandom));
    ga.delete();
    gd.delete();
    nb = 0; cyc = 0; nd = 0; ne = 0; dcyc = -1; budget = 40 * n + 100;
    fin = 0; to = 0; prev_rdy = 0; prev_wr = 0; ab_pend = 0; rs_pend = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    start = 1'b1;
    word_count = 9'(n);
    abort = 1'($urandom);
    in_valid = 1'($urandom);
    in_data = bq[0];
    while (!fin) begin
      @(posedge clk); #1;
      cyc++;
      start = prev_rdy && !abort && reset && $urandom_range(0, 3) == 0;
      word_count = 9'($urandom);
      abort = ab_pend || (prev_wr && ab < 0 && rs < 0 && ga.size() == n && $urandom_range(0, 1) == 1);
      rst_chk = !reset;
      reset = !rs_pend;
      ab_pend = 0;
      rs_pend = 0;
      in_valid = mode == 0 ? 1'b1 : mode == 1 ? cyc[0] : ($urandom_range(0, 2) == 0);
      in_data = bq[nb];
      @(negedge clk);
      if (rst_chk) chk("reset_outputs", {in_ready, WrEn, WrAddress, WrData, cpu_hold, done, err}, 69'd0);
      if (WrEn) begin
        ga.push_back(WrAddress);
        gd.push_back(WrData);
        chk("ready_in_write", in_ready, 1'b0);
      end
      if (done) begin nd++; dcyc = cyc; end
      if (err) ne++;
      if (in_valid && in_ready) begin
        nb++;
        if (nb == ab) ab_pend = 1;
        if (nb == rs) rs_pend = 1;
      end
      prev_rdy = in_ready;
      prev_wr = WrEn;
      to = cyc >= budget;
      fin = !cpu_hold || to;
    end
    okn = n >= 1 && n <= 256;
    normal = okn && ab < 0 && rs < 0;
    exp_w = !okn ? 0 : ab > 0 ? (ab - 1) / 4 : rs > 0 ? rs / 4 : n;
    chk("timeout", to, 1'b0);
    chk("write_count", ga.size(), exp_w);
    for (int k = 0; k < ga.size() && k < exp_w; k++) begin
      chk("wr_addr", ga[k], 32'(4 * k));
      chk("wr_data", gd[k], {bq[4*k], bq[4*k+1], bq[4*k+2], bq[4*k+3]});
    end
    chk("done_count", nd, normal ? 1 : 0);
    chk("err_count", ne, okn ? 0 : 1);
    if (normal) chk("bytes_taken", nb, 4 * n);
    if (normal && mode == 0) chk("done_cycle", dcyc, 5 * n + 1);
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'($urandom);
    in_valid = 1'($urandom);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_outputs", {in_ready, WrEn, WrAddress, WrData, cpu_hold, done, err}, 69'd0);
    bq.delete();
  endtask
  initial begin
    reset = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {in_ready, WrEn, WrAddress, WrData, cpu_hold, done, err}, 69'd0);
    start = 1'b0;
    abort = 1'b0;
    bq = '{8'h08, 8'h00, 8'h00, 8'h0E, 8'h08, 8'h00, 8'h00, 8'h15};
    load(2, 0, -1, -1);
    load(0, 0, -1, -1);
    load(257, 0, -1, -1);
    bq = '{8'h20, 8'h04, 8'h00, 8'h1C};
    load(1, 1, -1, -1);
    load(3, 0, 2, -1);
    load(1, 0, -1, -1);
    load(4, 0, -1, 12);
    load(3, 2, 8, -1);
    load(2, 2, -1, 5);
    for (int i = 0; i < 6; i++) load($urandom_range(1, 12), $urandom_range(0, 2), -1, -1);
    load(256, 0, -1, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
